// File: rtl/pll_lock_sequencer.sv
// PLL reset/lock sequencer: pulses the PLL reset, waits for a synchronized lock,
// qualifies it over a settle window, and re-locks or faults on failure.
module pll_lock_sequencer #(
  parameter  int RST_CYCLES    = 16,
  parameter  int LOCK_TIMEOUT  = 4096,
  parameter  int SETTLE_CYCLES = 256,
  parameter  int MAX_RETRIES   = 3,
  parameter  int CNT_W         = 8,
  localparam int RETRY_W       = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1
) (
  input  logic               refclk,
  input  logic               rst,
  input  logic               pll_locked,
  input  logic               relock_req,
  output logic               pll_rst,
  output logic               pll_ready,
  output logic               pll_fault,
  output logic [2:0]         state,
  output logic [RETRY_W-1:0] retry_cnt,
  output logic [CNT_W-1:0]   unlock_cnt
);

  localparam int MAX_A   = (RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES;
  localparam int MAX_CNT = (MAX_A > LOCK_TIMEOUT) ? MAX_A : LOCK_TIMEOUT;
  localparam int CW      = (MAX_CNT > 2) ? $clog2(MAX_CNT) : 1;

  typedef enum logic [2:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    SETTLE    = 3'd2,
    READY     = 3'd3,
    FAULT     = 3'd4
  } state_t;

  state_t             st, nxt_st;
  logic [CW-1:0]      cnt, nxt_cnt;
  logic [RETRY_W-1:0] retry, nxt_retry;
  logic               unlock_evt;
  logic               sync1, lock_s;

  // One shared counter: each state restarts it from zero on entry.
  always_comb begin
    nxt_st     = st;
    nxt_cnt    = cnt;
    nxt_retry  = retry;
    unlock_evt = 1'b0;
    case (st)
      RESET_PLL: begin
        if (cnt == CW'(RST_CYCLES - 1)) begin
          nxt_st  = WAIT_LOCK;
          nxt_cnt = '0;
        end else begin
          nxt_cnt = cnt + CW'(1);
        end
      end
      WAIT_LOCK: begin
        if (lock_s) begin
          nxt_st  = SETTLE;
          nxt_cnt = '0;
        end else if (cnt == CW'(LOCK_TIMEOUT - 1)) begin
          nxt_cnt = '0;
          if (retry == RETRY_W'(MAX_RETRIES)) begin
            nxt_st = FAULT;
          end else begin
            nxt_st    = RESET_PLL;
            nxt_retry = retry + RETRY_W'(1);
          end
        end else begin
          nxt_cnt = cnt + CW'(1);
        end
      end
      SETTLE: begin
        if (!lock_s) begin
          nxt_st  = WAIT_LOCK;
          nxt_cnt = '0;
        end else if (cnt == CW'(SETTLE_CYCLES - 1)) begin
          nxt_st    = READY;
          nxt_cnt   = '0;
          nxt_retry = '0;
        end else begin
          nxt_cnt = cnt + CW'(1);
        end
      end
      READY: begin
        if (!lock_s) begin
          nxt_st     = RESET_PLL;
          nxt_cnt    = '0;
          unlock_evt = 1'b1;
        end
      end
      FAULT: begin
        nxt_st = FAULT;
      end
      default: begin
        nxt_st  = RESET_PLL;
        nxt_cnt = '0;
      end
    endcase
    // Relock overrides the transition but keeps any lock-loss event counted.
    if (relock_req) begin
      nxt_st    = RESET_PLL;
      nxt_cnt   = '0;
      nxt_retry = '0;
    end
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      sync1      <= 1'b0;
      lock_s     <= 1'b0;
      st         <= RESET_PLL;
      cnt        <= '0;
      retry      <= '0;
      unlock_cnt <= '0;
      pll_rst    <= 1'b1;
      pll_ready  <= 1'b0;
      pll_fault  <= 1'b0;
    end else begin
      sync1     <= pll_locked;
      lock_s    <= sync1;
      st        <= nxt_st;
      cnt       <= nxt_cnt;
      retry     <= nxt_retry;
      if (unlock_evt && (unlock_cnt != '1))
        unlock_cnt <= unlock_cnt + CNT_W'(1);
      pll_rst   <= (nxt_st == RESET_PLL) || (nxt_st == FAULT);
      pll_ready <= (nxt_st == READY);
      pll_fault <= (nxt_st == FAULT);
    end
  end

  assign state     = st;
  assign retry_cnt = retry;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer: lock, timeout/fault, glitch, loss of lock,
// relock collisions, mid-sequence reset and unlock counter saturation.
module tb_pll_lock_sequencer;

  localparam int RST_CYCLES    = 4;
  localparam int LOCK_TIMEOUT  = 32;
  localparam int SETTLE_CYCLES = 8;
  localparam int MAX_RETRIES   = 2;
  localparam int CNT_W         = 8;
  localparam int LIMIT         = 200;
  localparam int SIG_RST       = 0;
  localparam int SIG_READY     = 1;
  localparam int SIG_STATE     = 2;

  logic             refclk = 1'b0;
  logic             rst, pll_locked, relock_req;
  logic             pll_rst, pll_ready, pll_fault;
  logic [2:0]       state;
  logic [1:0]       retry_cnt;
  logic [CNT_W-1:0] unlock_cnt;

  int checks = 0;
  int errors = 0;

  pll_lock_sequencer #(
    .RST_CYCLES   (RST_CYCLES),
    .LOCK_TIMEOUT (LOCK_TIMEOUT),
    .SETTLE_CYCLES(SETTLE_CYCLES),
    .MAX_RETRIES  (MAX_RETRIES),
    .CNT_W        (CNT_W)
  ) dut (
    .refclk    (refclk),
    .rst       (rst),
    .pll_locked(pll_locked),
    .relock_req(relock_req),
    .pll_rst   (pll_rst),
    .pll_ready (pll_ready),
    .pll_fault (pll_fault),
    .state     (state),
    .retry_cnt (retry_cnt),
    .unlock_cnt(unlock_cnt)
  );

  always #5 refclk = ~refclk;

  task automatic tick();
    @(posedge refclk);
    #1;
  endtask

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int unsigned sig(input int which);
    case (which)
      SIG_RST:   return int'(pll_rst);
      SIG_READY: return int'(pll_ready);
      SIG_STATE: return int'(state);
      default:   return int'(pll_fault);
    endcase
  endfunction

  // Edges until the selected output reaches target, bounded by LIMIT.
  task automatic wait_sig(input int which, input int unsigned target, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while ((sig(which) != target) && (n < LIMIT));
  endtask

  task automatic check_outs(input string tag, input int unsigned st, input int unsigned prst,
                            input int unsigned rdy, input int unsigned flt);
    check({tag, "_state"}, state, st);
    check({tag, "_pll_rst"}, pll_rst, prst);
    check({tag, "_ready"}, pll_ready, rdy);
    check({tag, "_fault"}, pll_fault, flt);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout expected finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    int n;
    int unsigned exp_unl;
    rst = 1'b1;
    pll_locked = 1'b0;
    relock_req = 1'b0;
    tick();
    tick();
    check_outs("reset", 0, 1, 0, 0);
    check("reset_retry", retry_cnt, 0);
    check("reset_unlock", unlock_cnt, 0);

    // Nominal lock
    rst = 1'b0;
    wait_sig(SIG_RST, 0, n);
    check("nom_rst_pulse", n, 4);
    check("nom_wait_state", state, 1);
    repeat (10) tick();
    pll_locked = 1'b1;
    wait_sig(SIG_STATE, 2, n);
    check("nom_settle_lat", n, 3);
    wait_sig(SIG_READY, 1, n);
    check("nom_ready_lat", n, 8);
    check_outs("nom_ready", 3, 0, 1, 0);
    check("nom_retry", retry_cnt, 0);

    // Loss of lock in READY
    pll_locked = 1'b0;
    wait_sig(SIG_READY, 0, n);
    check("loss_lat", n, 3);
    check_outs("loss", 0, 1, 0, 0);
    check("loss_unlock", unlock_cnt, 1);
    check("loss_retry", retry_cnt, 0);
    wait_sig(SIG_RST, 0, n);
    check("loss_rst_pulse", n, 4);

    // Timeouts escalate to FAULT
    wait_sig(SIG_STATE, 0, n);
    check("to1_window", n, 32);
    check("to1_retry", retry_cnt, 1);
    check("to1_pll_rst", pll_rst, 1);
    wait_sig(SIG_RST, 0, n);
    check("to1_rst_pulse", n, 4);
    wait_sig(SIG_STATE, 0, n);
    check("to2_window", n, 32);
    check("to2_retry", retry_cnt, 2);
    wait_sig(SIG_RST, 0, n);
    check("to2_rst_pulse", n, 4);
    wait_sig(SIG_STATE, 4, n);
    check("to3_window", n, 32);
    check_outs("fault", 4, 1, 0, 1);
    check("fault_retry", retry_cnt, 2);
    repeat (5) tick();
    check_outs("fault_sticky", 4, 1, 0, 1);

    // Relock out of FAULT
    relock_req = 1'b1;
    tick();
    relock_req = 1'b0;
    check_outs("relock", 0, 1, 0, 0);
    check("relock_retry", retry_cnt, 0);
    wait_sig(SIG_RST, 0, n);
    check("relock_rst_pulse", n, 4);

    // Settle glitch after one timeout: retry count must survive the glitch
    wait_sig(SIG_STATE, 0, n);
    check("gl_timeout", n, 32);
    wait_sig(SIG_RST, 0, n);
    check("gl_rst_pulse", n, 4);
    pll_locked = 1'b1;
    wait_sig(SIG_STATE, 2, n);
    check("gl_settle_lat", n, 3);
    repeat (4) tick();
    pll_locked = 1'b0;
    tick();
    tick();
    check_outs("gl_still_settle", 2, 0, 0, 0);
    tick();
    check("gl_back_wait", state, 1);
    check("gl_retry", retry_cnt, 1);
    pll_locked = 1'b1;
    wait_sig(SIG_STATE, 2, n);
    check("gl_resettle_lat", n, 3);
    wait_sig(SIG_READY, 1, n);
    check("gl_ready_lat", n, 8);
    check("gl_retry_clear", retry_cnt, 0);

    // relock_req on the edge the FSM sees lock_s low
    pll_locked = 1'b0;
    tick();
    tick();
    relock_req = 1'b1;
    tick();
    relock_req = 1'b0;
    check_outs("sim", 0, 1, 0, 0);
    check("sim_unlock", unlock_cnt, 2);
    tick();
    tick();
    relock_req = 1'b1;
    tick();
    relock_req = 1'b0;
    check("sim_relock2_rst", pll_rst, 1);
    check("sim_unlock_hold", unlock_cnt, 2);
    wait_sig(SIG_RST, 0, n);
    check("sim_ext_pulse", n, 4);

    // Synchronous reset during SETTLE
    pll_locked = 1'b1;
    wait_sig(SIG_STATE, 2, n);
    check("mid_settle_lat", n, 3);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_outs("mid_reset", 0, 1, 0, 0);
    check("mid_retry", retry_cnt, 0);
    check("mid_unlock", unlock_cnt, 0);
    wait_sig(SIG_RST, 0, n);
    check("mid_rst_pulse", n, 4);
    wait_sig(SIG_READY, 1, n);
    check("mid_ready_lat", n, 9);

    // Unlock counter saturation
    exp_unl = 0;
    for (int i = 0; i < 260; i++) begin
      pll_locked = 1'b0;
      wait_sig(SIG_READY, 0, n);
      check("sat_loss_lat", n, 3);
      exp_unl = (exp_unl == 255) ? 255 : exp_unl + 1;
      check("sat_unlock", unlock_cnt, exp_unl);
      pll_locked = 1'b1;
      wait_sig(SIG_READY, 1, n);
      check("sat_relock_lat", n, 13);
    end
    check("sat_final", unlock_cnt, 255);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pll_lock_sequencer.md
# pll_lock_sequencer

Sequences the reset and lock qualification of the reconfigurable PLL in the MuTRiG reset-controller clocking path. It pulses the PLL reset and waits for `locked` within a timeout. It then qualifies lock over a settle window before asserting `pll_ready` to downstream reset logic. Loss of lock triggers an automatic re-lock, and repeated lock timeouts end in a sticky fault.

## Interface

Parameters:
- `RST_CYCLES`, 16: cycles `pll_rst` is held high per reset attempt (≥1).
- `LOCK_TIMEOUT`, 4096: cycles allowed in WAIT_LOCK before the attempt is declared failed (≥4).
- `SETTLE_CYCLES`, 256: consecutive synchronized-lock cycles required before READY (≥1).
- `MAX_RETRIES`, 3: additional reset attempts after the first timeout before FAULT (≥0).
- `CNT_W`, 8: width of the unlock event counter.

Ports:
- `refclk`  in  1  free-running block clock; also the PLL reference clock.
- `rst`  in  1  synchronous, active-high reset.
- `pll_locked`  in  1  PLL `locked` output; asynchronous to `refclk`.
- `relock_req`  in  1  single-cycle request to restart the sequence.
- `pll_rst`  out  1  registered reset to the PLL `rst` input.
- `pll_ready`  out  1  registered; high only in READY.
- `pll_fault`  out  1  registered; high only in FAULT.
- `state`  out  3  current state encoding.
- `retry_cnt`  out  clog2(MAX_RETRIES+1), min 1  timeouts in the current sequence.
- `unlock_cnt`  out  CNT_W  saturating count of lock losses seen in READY.

## Operation

- `pll_locked` passes through a 2-FF synchronizer to give `lock_s`. `lock_s` lags `pll_locked` by 2 edges. All decisions use `lock_s`.
- State encoding: RESET_PLL=0, WAIT_LOCK=1, SETTLE=2, READY=3, FAULT=4. Codes 5–7 are illegal and go to RESET_PLL on the next edge.
- RESET_PLL:
  - `pll_rst`=1; a cycle counter runs.
  - After `RST_CYCLES` cycles in the state, go to WAIT_LOCK.
- WAIT_LOCK:
  - `pll_rst`=0; a timeout counter runs from 0.
  - `lock_s`=1: go to SETTLE.
  - Otherwise, after `LOCK_TIMEOUT` cycles: if `retry_cnt`==`MAX_RETRIES`, go to FAULT; else increment `retry_cnt` and go to RESET_PLL.
- SETTLE:
  - A settle counter counts consecutive cycles with `lock_s`=1.
  - `lock_s`=0: go back to WAIT_LOCK with the timeout counter restarted. This is not a retry.
  - After `SETTLE_CYCLES` consecutive high cycles: go to READY and clear `retry_cnt`.
- READY:
  - `pll_ready`=1.
  - `lock_s`=0: increment `unlock_cnt` (saturates at 2^CNT_W−1) and go to RESET_PLL. `retry_cnt` stays 0.
- FAULT:
  - `pll_fault`=1 and `pll_rst`=1, so the PLL is held in reset.
  - Sticky; only `relock_req` or `rst` exits.
- `relock_req`:
  - Has priority over every other transition, in any state.
  - Next state is RESET_PLL with the RST counter restarted and `retry_cnt` cleared. `unlock_cnt` is unchanged.
  - In READY together with `lock_s`=0: go to RESET_PLL and still increment `unlock_cnt`.
  - In RESET_PLL: restarts the full `RST_CYCLES` pulse.
- `unlock_cnt` is cleared only by `rst`.

## Timing

- Reset values (at the edge where `rst` is sampled high):
  - state=RESET_PLL, `pll_rst`=1, `pll_ready`=0, `pll_fault`=0.
  - `retry_cnt`=0, `unlock_cnt`=0.
  - All internal counters and synchronizer flops = 0.
- Counters hold in reset while `rst`=1. The first edge with `rst`=0 is RESET_PLL cycle 1.
- `rst` asserted mid-operation aborts immediately: reset values apply at that edge and `pll_ready` drops at that edge.
- `pll_rst` falls exactly `RST_CYCLES` edges after RESET_PLL entry.
- Lock path:
  - `pll_locked` rising while in WAIT_LOCK → SETTLE entry 3 edges later (2 synchronizer edges + 1 FSM edge).
  - `pll_ready` rises `SETTLE_CYCLES` edges after SETTLE entry.
- Timeout path: WAIT_LOCK→RESET_PLL (or →FAULT) on edge `LOCK_TIMEOUT` after WAIT_LOCK entry.
- Loss of lock:
  - `pll_locked` falling while in READY → `pll_ready` low and `pll_rst` high 3 edges later.
  - `unlock_cnt` updates on the same edge.
- `relock_req` sampled high → state=RESET_PLL and `pll_rst`=1 on the next edge.
- All outputs are registered: no combinational path from an input to an output.

## Test plan

Bench parameters for all scenarios: RST_CYCLES=4, LOCK_TIMEOUT=32, SETTLE_CYCLES=8, MAX_RETRIES=2.

- **Nominal lock:** release `rst`; raise `pll_locked` 10 cycles after `pll_rst` falls.
  - `pll_rst` high for 4 cycles.
  - SETTLE entered 3 cycles after `pll_locked` rises; `pll_ready` high 8 cycles after that.
  - `retry_cnt`=0.
- **Timeout to fault:** hold `pll_locked`=0.
  - Three `pll_rst` pulses of 4 cycles each, separated by 32-cycle WAIT_LOCK windows.
  - `retry_cnt` steps 0→1→2; FAULT (state=4) with `pll_fault`=1 and `pll_rst`=1.
  - Then pulse `relock_req`: RESET_PLL next edge, `retry_cnt`=0, `pll_fault`=0.
- **Settle glitch:** drop `pll_locked` for 3 cycles at SETTLE cycle 5.
  - Return to WAIT_LOCK; `retry_cnt` unchanged.
  - `pll_ready` rises only after 8 fresh consecutive locked cycles.
- **Loss of lock in READY:** deassert `pll_locked` once READY.
  - `pll_ready` falls 3 edges later; `unlock_cnt`=1; a new 4-cycle `pll_rst` pulse follows.
  - Repeat 260 times with CNT_W=8: `unlock_cnt` saturates at 255.
- **Simultaneous events:** in READY, pulse `relock_req` on the same edge that `lock_s` falls.
  - RESET_PLL next edge; `unlock_cnt` increments by exactly 1.
  - A second `relock_req` at RESET_PLL cycle 3 extends the `pll_rst` pulse to 3+4 cycles.
- **Reset mid-sequence:** assert `rst` for 1 cycle during SETTLE.
  - All outputs return to reset values at that edge, including `unlock_cnt`=0.
  - The sequence restarts with a full 4-cycle `pll_rst` pulse.
